// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex reporter: ASCII constants, frame length,
// nibble-to-ASCII encoding and the report FSM state type.
package uart_pkg;

   localparam logic [7:0] CHAR_C  = 8'h43;
   localparam logic [7:0] CHAR_SP = 8'h20;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   localparam int FRAME_LEN = 11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_FINISH
   } rpt_state_e;

   // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F'
   function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART serialiser, LSB first. Each bit is held for OVERSAMPLE baud ticks
// counted from the cycle the bit is first driven.
module uart_tx_8n1
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       baud_tick_i,
   input  logic [7:0] data_i,
   input  logic       load_i,
   output logic       tx_o,
   output logic       ready_o
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

   logic              busy_q, busy_d;
   logic              tx_q, tx_d;
   logic [8:0]        shreg_q, shreg_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         tx_q       <= 1'b1;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         tick_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         tx_q       <= tx_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // shreg holds the bits still to be sent after the one on the line: data then stop
   always_comb begin
      busy_d     = busy_q;
      tx_d       = tx_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      tick_cnt_d = tick_cnt_q;
      if (!busy_q) begin
         if (load_i) begin
            busy_d     = 1'b1;
            tx_d       = 1'b0;
            shreg_d    = {1'b1, data_i};
            bit_cnt_d  = 4'd0;
            tick_cnt_d = '0;
         end
      end else if (baud_tick_i) begin
         if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (bit_cnt_q == 4'd9) begin
               busy_d = 1'b0;
               tx_d   = 1'b1;
            end else begin
               tx_d      = shreg_q[0];
               shreg_d   = {1'b1, shreg_q[8:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end
   end

   assign tx_o    = tx_q;
   assign ready_o = ~busy_q;

endmodule

// File: rtl/uart_hex_reporter.sv
// Sends "C<5 hex count> <2 hex sum>\r\n" over UART on each accepted start pulse,
// using a snapshot of count and sum taken when start is accepted.
module uart_hex_reporter
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             baud_tick_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic [7:0]       sum_i,
   output logic             tx_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

   rpt_state_e  state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [19:0] cnt_q, cnt_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  byte_sel;
   logic        ser_load;
   logic        ser_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      ser_load = 1'b0;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               cnt_d   = 20'(count_i);
               sum_d   = sum_i;
               idx_d   = 4'd0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy_o   = 1'b1;
            ser_load = 1'b1;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            busy_o = 1'b1;
            if (ser_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_FINISH;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_FINISH: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      byte_sel = CHAR_C;
      unique case (idx_q)
         4'd0:    byte_sel = CHAR_C;
         4'd1:    byte_sel = hex2ascii(cnt_q[19:16]);
         4'd2:    byte_sel = hex2ascii(cnt_q[15:12]);
         4'd3:    byte_sel = hex2ascii(cnt_q[11:8]);
         4'd4:    byte_sel = hex2ascii(cnt_q[7:4]);
         4'd5:    byte_sel = hex2ascii(cnt_q[3:0]);
         4'd6:    byte_sel = CHAR_SP;
         4'd7:    byte_sel = hex2ascii(sum_q[7:4]);
         4'd8:    byte_sel = hex2ascii(sum_q[3:0]);
         4'd9:    byte_sel = CHAR_CR;
         4'd10:   byte_sel = CHAR_LF;
         default: byte_sel = CHAR_C;
      endcase
   end

   uart_tx_8n1 #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tx (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick_i(baud_tick_i),
      .data_i     (byte_sel),
      .load_i     (ser_load),
      .tx_o       (tx_o),
      .ready_o    (ser_ready)
   );

endmodule

// File: doc/uart_hex_reporter.md
Name: uart_hex_reporter

Overview:
Transmit-side counterpart to the UART receive accumulator (20-bit byte count plus 8-bit running sum).
- On a start pulse, snapshots count and sum.
- Serialises them as an 11-byte ASCII frame over an 8N1 UART line, timed by the shared baudclk16 tick.
- Lets the host read back board statistics on uart_tx_o without firmware involvement.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per UART bit (must be >= 2)
CNT_W, 20, width of count input (fixed 5 hex digits; must be <= 20)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
baud_tick  in  1  one-cycle pulse at 16x baud rate (baudclk16)
start  in  1  one-cycle request to send a report frame
count  in  CNT_W  received-byte count to report
sum  in  8  running byte sum to report
tx  out  1  UART serial output, idle high
busy  out  1  high from the cycle after start is accepted until frame complete
done  out  1  one-cycle pulse when the last stop bit ends

Behaviour:
- Reset: rst_n is synchronous, active-low, on clock clk.
  - tx=1, busy=0, done=0.
  - FSM to IDLE; all counters and snapshot registers zeroed.
  - Reset mid-frame aborts immediately: tx returns high next cycle, no done pulse.
- Frame layout, fixed 11 bytes, in order: 'C'(0x43), count[19:16], count[15:12], count[11:8], count[7:4], count[3:0] as hex, ' '(0x20), sum[7:4], sum[3:0] as hex, CR(0x0D), LF(0x0A).
  - count is zero-extended to 20 bits.
- Hex encoding: nibble 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase).
- Accept: start sampled in IDLE snapshots count and sum into internal registers the same cycle.
  - busy=1 from next cycle.
  - Input changes after acceptance do not affect the frame.
  - start while busy is ignored: no queueing, no restart.
- Top FSM: IDLE -> LOAD -> SEND -> (next byte ? LOAD : FINISH) -> IDLE.
  - LOAD: selects byte by index 0..10 and hands it to the serialiser.
  - SEND: waits for serialiser completion.
  - FINISH: pulses done for 1 cycle, clears busy in the same cycle as done.
- Serialiser (8N1, LSB first):
  - Start bit 0, d[0]..d[7], stop bit 1.
  - Each bit lasts exactly OVERSAMPLE baud_tick pulses, counted from the cycle the bit is driven.
  - The first bit may be stretched by less than one tick period (alignment).
  - A bit ends on the cycle its OVERSAMPLE-th tick is seen; the next bit is driven the following cycle.
- Inter-byte gap: next start bit follows the stop bit with at most 2 clk cycles of idle-high; no extra bit times.
- baud_tick low indefinitely: block holds state; tx holds current bit level.
- Simultaneous start and rst_n=0: reset wins.
- Byte index counter 0..10; no wrap; terminates at 10.

Decomposition:
- Shared package uart_pkg:
  - ASCII constants: CHAR_C, CHAR_SP, CHAR_CR, CHAR_LF.
  - FRAME_LEN = 11.
  - Hex-to-ASCII function.
  - Top FSM state enum.
- One sub-module: uart_tx_8n1.
  - Ports: clk, rst_n, baud_tick, data[7:0], load, tx, ready.
  - Parameter OVERSAMPLE.
  - Owns the bit and tick counters.
- Top level owns the snapshot registers, byte mux and frame FSM.

Test Plan:
- Basic frame: baud_tick every cycle, OVERSAMPLE=16, count=0x12345, sum=0xA7, one start pulse.
  - Decoded bytes 43 31 32 33 34 35 20 41 37 0D 0A.
  - Each bit 16 cycles; done exactly once; busy low after.
- Extremes: count=0xFFFFF, sum=0x00.
  - Bytes 43 46 46 46 46 46 20 30 30 0D 0A.
  - Then count=0, sum=0xFF -> 43 30 30 30 30 30 20 46 46 0D 0A.
- Snapshot and ignore: change count and sum every cycle after start; pulse start again mid-frame.
  - Frame carries the accepted values only.
  - Exactly one frame and one done.
- Sparse ticks: baud_tick every 27 cycles.
  - Each bit width is 16 ticks (±1 tick on the first bit of a byte).
  - Stop bit high; idle high between frames.
- Reset mid-frame: assert rst_n=0 during byte 4 bit 3.
  - tx=1, busy=0 next cycle; no done pulse.
  - New start after release yields a full correct frame.
- Back-to-back: start pulsed the cycle after done.
  - Second frame accepted; total line time equals 2 × 11 × 10 × OVERSAMPLE ticks, plus at most 2 cycles per byte gap.
